// File: rtl/mul8_arb_pkg.sv
// Shared types, constants and helpers for the mul8_arbiter slice.
package mul8_arb_pkg;

  localparam int MUL_W       = 8;
  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_CAP,
    S_RESP
  } state_t;

  // Index 'off' positions after 'base', wrapping modulo n.
  function automatic int wrap_inc(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/mul8_arb_rr.sv
// Combinational grant picker: round-robin from last_grant+1, or lowest-index
// fixed priority when MUL8_ARB_FIXED_PRIO_EN is defined.
module mul8_arb_rr
  import mul8_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
`ifndef MUL8_ARB_FIXED_PRIO_EN
  input  logic [ID_W-1:0]    i_last_grant,
`endif
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  always_comb begin
    // NOTE: every output gets a default before the search, so no path infers a latch.
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
`ifdef MUL8_ARB_FIXED_PRIO_EN
    // Descending scan: the last hit written is the lowest valid index.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_valid[ID_W'(i)]) begin
        o_grant             = '0;
        o_grant[ID_W'(i)]   = 1'b1;
        o_idx               = ID_W'(i);
        o_any               = 1'b1;
      end
    end
`else
    // Descending offset scan: the last hit written is the one nearest last_grant+1.
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (i_valid[ID_W'(wrap_inc(int'(i_last_grant), off, NUM_REQ))]) begin
        o_grant = '0;
        o_grant[ID_W'(wrap_inc(int'(i_last_grant), off, NUM_REQ))] = 1'b1;
        o_idx   = ID_W'(wrap_inc(int'(i_last_grant), off, NUM_REQ));
        o_any   = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/mul8_parall.sv
// Shared 8-bit multiplier: registered low byte of a*b, no reset.
module mul8_parall (
  input  logic       clk,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  // NOTE: datapath register carries no reset; its value is only consumed after a full operand load.
  always_ff @(posedge clk) begin
    p_o <= a_i * b_i;
  end

endmodule

// File: rtl/mul8_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared mul8_parall multiplier.
// Define MUL8_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mul8_arbiter
  import mul8_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*MUL_W-1:0] req_a_i,
  input  logic [NUM_REQ*MUL_W-1:0] req_b_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [MUL_W-1:0]         resp_p_o,
  output logic [ID_W-1:0]          resp_id_o,
  output logic                     busy_o
);

  if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
    $error("mul8_arbiter: NUM_REQ out of range");
  end

  state_t             r_state, w_state_nxt;
  logic [MUL_W-1:0]   r_a, r_b, r_resp_p, w_p;
  logic [ID_W-1:0]    r_id, w_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_any, w_hs;
  logic [MUL_W-1:0]   w_a_arr [NUM_REQ];
  logic [MUL_W-1:0]   w_b_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign w_a_arr[k] = req_a_i[k*MUL_W +: MUL_W];
    assign w_b_arr[k] = req_b_i[k*MUL_W +: MUL_W];
  end

`ifndef MUL8_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0] r_last_grant;
`endif

  mul8_arb_rr #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_pick (
    .i_valid     (req_valid_i),
`ifndef MUL8_ARB_FIXED_PRIO_EN
    .i_last_grant(r_last_grant),
`endif
    .o_grant     (w_grant),
    .o_idx       (w_idx),
    .o_any       (w_any)
  );

  mul8_parall u_mul (
    .clk(clk),
    .a_i(r_a),
    .b_i(r_b),
    .p_o(w_p)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Reset gates the grant so no handshake is offered while held in reset.
        if (w_any && !rst) begin
          w_hs        = 1'b1;
          w_state_nxt = S_MUL;
        end
      end
      S_MUL:   w_state_nxt = S_CAP;
      S_CAP:   w_state_nxt = S_RESP;
      S_RESP:  if (resp_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= '0;
      r_resp_p     <= '0;
`ifndef MUL8_ARB_FIXED_PRIO_EN
      r_last_grant <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_a          <= w_a_arr[w_idx];
        r_b          <= w_b_arr[w_idx];
        r_id         <= w_idx;
`ifndef MUL8_ARB_FIXED_PRIO_EN
        r_last_grant <= w_idx;
`endif
      end
      if (r_state == S_CAP) r_resp_p <= w_p;
    end
  end

  assign req_ready_o  = w_hs ? w_grant : '0;
  assign resp_valid_o = (r_state == S_RESP);
  assign resp_p_o     = r_resp_p;
  assign resp_id_o    = r_id;
  assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mul8_arbiter.sv
// Self-checking bench for mul8_arbiter: directed table, corner sequences, random vs model.
module tb_mul8_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid_i;
  logic [NUM_REQ*8-1:0]   req_a_i, req_b_i;
  logic [NUM_REQ-1:0]     req_ready_o;
  logic                   resp_valid_o;
  logic                   resp_ready_i;
  logic [7:0]             resp_p_o;
  logic [ID_W-1:0]        resp_id_o;
  logic                   busy_o;

  int n_pass  = 0;
  int n_total = 0;
  int m_last  = NUM_REQ - 1;

  mul8_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .req_ready_o (req_ready_o),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_p_o    (resp_p_o),
    .resp_id_o   (resp_id_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant rule straight from the arbitration description.
  function automatic int model_pick(input logic [NUM_REQ-1:0] mask, input int last);
`ifdef MUL8_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) if (mask[i]) return i;
`else
    for (int off = 1; off <= NUM_REQ; off++)
      if (mask[(last + off) % NUM_REQ]) return (last + off) % NUM_REQ;
`endif
    return -1;
  endfunction

  function automatic logic [7:0] model_prod(input logic [NUM_REQ*8-1:0] a, b, input int id);
    int pa, pb;
    pa = int'(a[id*8 +: 8]);
    pb = int'(b[id*8 +: 8]);
    return 8'((pa * pb) % 256);
  endfunction

  // One full transaction starting in IDLE: grant, MUL, CAP, RESP (+stall), back to IDLE.
  task automatic run_txn(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ*8-1:0] a,
                         input logic [NUM_REQ*8-1:0] b, input int stall, input int exp_id,
                         input logic [7:0] exp_p, input string tag);
    logic [NUM_REQ-1:0] exp_rdy;
    exp_rdy         = '0;
    exp_rdy[exp_id] = 1'b1;
    req_valid_i  = mask;
    req_a_i      = a;
    req_b_i      = b;
    resp_ready_i = (stall == 0);
    #1;
    check({tag, ".grant"}, 32'(req_ready_o), 32'(exp_rdy));
    tick();
    check({tag, ".mul_rdy"}, 32'(req_ready_o), 32'd0);
    check({tag, ".mul_busy"}, 32'(busy_o), 32'd1);
    check({tag, ".mul_vld"}, 32'(resp_valid_o), 32'd0);
    tick();
    check({tag, ".cap_vld"}, 32'(resp_valid_o), 32'd0);
    tick();
    check({tag, ".resp_vld"}, 32'(resp_valid_o), 32'd1);
    check({tag, ".resp_p"}, 32'(resp_p_o), 32'(exp_p));
    check({tag, ".resp_id"}, 32'(resp_id_o), 32'(exp_id));
    check({tag, ".resp_rdy"}, 32'(req_ready_o), 32'd0);
    for (int s = 0; s < stall; s++) begin
      req_a_i = {$urandom};
      req_b_i = {$urandom};
      tick();
      check({tag, ".stall_vld"}, 32'(resp_valid_o), 32'd1);
      check({tag, ".stall_p"}, 32'(resp_p_o), 32'(exp_p));
      check({tag, ".stall_id"}, 32'(resp_id_o), 32'(exp_id));
      check({tag, ".stall_rdy"}, 32'(req_ready_o), 32'd0);
    end
    resp_ready_i = 1'b1;
    tick();
    m_last = exp_id;
    check({tag, ".done_vld"}, 32'(resp_valid_o), 32'd0);
    check({tag, ".done_busy"}, 32'(busy_o), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_last = NUM_REQ - 1;
  endtask

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    int         stall;
  } vec_t;

  vec_t vec [7];
  int   fair_order [5];

  initial begin
    logic [NUM_REQ*8-1:0] a, b;
    logic [NUM_REQ-1:0]   mask;
    int                   id;

    vec[0] = '{1, 8'd13,  8'd11,  8'd143, 0};
    vec[1] = '{0, 8'd200, 8'd3,   8'd88,  0};
    vec[2] = '{3, 8'd255, 8'd255, 8'd1,   0};
    vec[3] = '{2, 8'd16,  8'd16,  8'd0,   5};
    vec[4] = '{1, 8'd15,  8'd17,  8'd255, 1};
    vec[5] = '{0, 8'd0,   8'd77,  8'd0,   0};
    vec[6] = '{3, 8'd7,   8'd9,   8'd63,  2};
`ifdef MUL8_ARB_FIXED_PRIO_EN
    fair_order = '{0, 0, 0, 0, 0};
`else
    fair_order = '{0, 1, 2, 3, 0};
`endif

    // Reset state, with every requester valid to show no grant leaks out.
    rst          = 1'b1;
    req_valid_i  = '1;
    req_a_i      = '1;
    req_b_i      = '1;
    resp_ready_i = 1'b0;
    #2;
    check("rst.ready", 32'(req_ready_o), 32'd0);
    check("rst.valid", 32'(resp_valid_o), 32'd0);
    check("rst.p", 32'(resp_p_o), 32'd0);
    check("rst.id", 32'(resp_id_o), 32'd0);
    check("rst.busy", 32'(busy_o), 32'd0);
    tick();
    rst         = 1'b0;
    req_valid_i = '0;
    m_last      = NUM_REQ - 1;
    tick();
    check("idle.ready", 32'(req_ready_o), 32'd0);
    check("idle.busy", 32'(busy_o), 32'd0);

    // Directed table: one requester at a time.
    for (int i = 0; i < 7; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      a[vec[i].id*8 +: 8] = vec[i].a;
      b[vec[i].id*8 +: 8] = vec[i].b;
      mask = '0;
      mask[vec[i].id] = 1'b1;
      run_txn(mask, a, b, vec[i].stall, vec[i].id, vec[i].p, $sformatf("vec%0d", i));
    end

    // Requester that would win drops valid; then a split request pattern.
    a = {8'd41, 8'd31, 8'd21, 8'd11};
    b = {8'd5, 8'd6, 8'd7, 8'd8};
    mask = 4'b1110;
    id = model_pick(mask, m_last);
    run_txn(mask, a, b, 0, id, model_prod(a, b, id), "drop");
    mask = 4'b1001;
    id = model_pick(mask, m_last);
    run_txn(mask, a, b, 0, id, model_prod(a, b, id), "split");

    // Fairness from reset with every requester continuously valid.
    tick();
    apply_reset();
    a = {8'd13, 8'd12, 8'd11, 8'd10};
    b = {8'd23, 8'd22, 8'd21, 8'd20};
    for (int i = 0; i < 5; i++)
      run_txn('1, a, b, 0, fair_order[i], model_prod(a, b, fair_order[i]), $sformatf("fair%0d", i));

    // Reset while in MUL: response dropped, requester 0 wins next.
    req_valid_i  = 4'b0100;
    req_a_i      = {8'd0, 8'd9, 8'd0, 8'd0};
    req_b_i      = {8'd0, 8'd9, 8'd0, 8'd0};
    resp_ready_i = 1'b1;
    #1;
    check("midrst.grant", 32'(req_ready_o), 32'h4);
    tick();
    req_valid_i = '1;
    rst         = 1'b1;
    #1;
    check("midrst.valid", 32'(resp_valid_o), 32'd0);
    check("midrst.busy", 32'(busy_o), 32'd0);
    check("midrst.p", 32'(resp_p_o), 32'd0);
    check("midrst.id", 32'(resp_id_o), 32'd0);
    check("midrst.ready", 32'(req_ready_o), 32'd0);
    tick();
    rst         = 1'b0;
    req_valid_i = '0;
    m_last      = NUM_REQ - 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst.quiet_vld", 32'(resp_valid_o), 32'd0);
      check("midrst.quiet_busy", 32'(busy_o), 32'd0);
    end
    a = {8'd4, 8'd3, 8'd2, 8'd19};
    b = {8'd4, 8'd3, 8'd2, 8'd7};
    run_txn('1, a, b, 0, 0, model_prod(a, b, 0), "postrst");

    // Random traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      a    = {$urandom};
      b    = {$urandom};
      id   = model_pick(mask, m_last);
      run_txn(mask, a, b, $urandom_range(0, 2), id, model_prod(a, b, id), $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) begin
        req_valid_i = '0;
        #1;
        check("rnd.gap_rdy", 32'(req_ready_o), 32'd0);
        tick();
        check("rnd.gap_busy", 32'(busy_o), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mul8_arbiter.md
# mul8_arbiter

Shares one `mul8_parall` 8-bit multiplier among `NUM_REQ` requesters. Each requester uses a valid/ready handshake. The block arbitrates among them and sequences operands into the multiplier. It then captures the registered product and returns it with the winner's ID over a response handshake that supports backpressure. It sits between the task-level request sources and the shared multiplier datapath.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `ID_W`, localparam `$clog2(NUM_REQ)`: width of the requester ID.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `req_valid_i` input `NUM_REQ`: per-requester request valid.
- `req_a_i` input `NUM_REQ*8`: operand A; requester k occupies bits [8k+7:8k].
- `req_b_i` input `NUM_REQ*8`: operand B, same packing as `req_a_i`.
- `req_ready_o` output `NUM_REQ`: one-hot accept. At most one bit is high per cycle.
- `resp_valid_o` output 1: a response is present.
- `resp_ready_i` input 1: the consumer accepts the response.
- `resp_p_o` output 8: product, (a*b) mod 256.
- `resp_id_o` output `ID_W`: index of the requester that owns the response.
- `busy_o` output 1: high in any state other than IDLE.

## Operation
The FSM has four states:
- **IDLE**:
  - If any `req_valid_i` bit is high, the arbiter picks a grant g.
  - `req_ready_o[g]` is asserted combinationally in the same cycle.
  - At the edge: latch `req_a_i[g]`, `req_b_i[g]` and g into the operand/ID registers, then go to MUL.
  - If no request is valid, stay in IDLE.
- **MUL**: the operand registers drive `mul8_parall`; the multiplier registers its product at this edge. Go to CAP.
- **CAP**: latch the multiplier `p_o` into the `resp_p` register. Go to RESP.
- **RESP**:
  - Hold `resp_valid_o`=1 with `resp_p_o` and `resp_id_o` stable.
  - If `resp_ready_i` is high, go to IDLE. Otherwise stay in RESP.
  - No grant is issued in RESP.

Arbitration and handshake rules:
- Arbitration is round-robin. Search starts at index `last_grant+1` and wraps modulo `NUM_REQ`.
- `last_grant` updates only on an accepted handshake.
- `req_ready_o` is all zeros in MUL, CAP and RESP.
- Requesters must hold their valid and operands until they see ready. The arbiter does not require that valid is sticky.
- Arithmetic: the multiplier returns the low 8 bits of the product. No overflow flag is produced. Operand registers are 8-bit unsigned.
- The multiplier has no reset. Its output is sampled only in CAP, so the value it holds after reset does not matter.

## Timing
- Handshake in cycle T, then `resp_valid_o` rises at T+3.
- With `resp_ready_i` tied high, the earliest next handshake is T+4. Throughput is 1 per 4 cycles.
- Each stall cycle in RESP adds one cycle of delay.
- Reset values:
  - State is IDLE and `req_ready_o` is 0.
  - `resp_valid_o`, `resp_p_o`, `resp_id_o` and `busy_o` are 0.
  - The operand registers are 0.
  - `last_grant` is `NUM_REQ-1`, so requester 0 wins first.
- Reset asserted mid-transaction: the in-flight operation is dropped silently with no response. All outputs go to their reset values immediately, without waiting for a clock edge.
- Case: a requester deasserts valid in the same cycle it would be granted. That requester is not in the grant set, so no handshake occurs for it.
- Case: all requesters are valid continuously. Grants rotate 0,1,2,…,NUM_REQ-1,0.

## Configuration
- `MUL8_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, where the lowest valid index always wins. `last_grant` is not implemented.
  - Undefined, the default: round-robin as described in Operation.

## Structure
- Package `mul8_arb_pkg` holds:
  - the state enum (IDLE, MUL, CAP, RESP);
  - `MUL_W` = 8;
  - the `NUM_REQ` legal-range constants.
- Sub-module `mul8_arb_rr` is the combinational picker. It takes the valid vector and `last_grant` and returns a one-hot grant plus the encoded index. Fixed-priority mode is selected inside it under the macro.
- The multiplier is a direct instance of `mul8_parall`, unmodified.

## Test plan
- Single request: requester 1 sends a=13, b=11 → `resp_valid_o` at T+3 with `resp_p_o`=143 and `resp_id_o`=1.
- Truncation: a=200, b=3 → `resp_p_o`=88. a=255, b=255 → `resp_p_o`=1.
- Fairness: all 4 requesters valid continuously, `resp_ready_i`=1 → grant order 0,1,2,3,0. With `MUL8_ARB_FIXED_PRIO_EN` the order is 0,0,0.
- Backpressure: hold `resp_ready_i`=0 for 5 cycles in RESP → outputs stay stable, `req_ready_o` stays 0, and exactly one response is accepted.
- Reset mid-operation: assert `rst` while in MUL → no response appears and the next request is granted to requester 0.
